alu_exec_unit: RTL and testbench

//  Parametrised successor to the single-cycle ALU control: decodes alu_op/funct and executes the op in one block.

---
 rtl/alu_exec_if.sv | 31 +++
 rtl/alu_exec_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Request/response bundle for alu_exec_unit.
//   master: drives in_valid, alu_op, funct, a, b, out_ready
//   slave : drives in_ready, out_valid, result, zero, illegal, hi, lo
`timescale 1ns/1ps
interface alu_exec_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, alu_op, funct, a, b, out_ready,
    input  in_ready, out_valid, result, zero, illegal, hi, lo
  );

  modport slave (
    input  in_valid, alu_op, funct, a, b, out_ready,
    output in_ready, out_valid, result, zero, illegal, hi, lo
  );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes alu_op/funct, executes single-cycle ops in one edge,
// and runs mult/multu/div/divu iteratively (one bit per cycle) into HI/LO.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_exec_if slave (valid/ready request in, valid/ready result out,
//                result/zero/illegal plus architectural hi/lo)
`timescale 1ns/1ps
module alu_exec_unit #(
  parameter int unsigned WIDTH         = 32,
  parameter bit          ENABLE_MULDIV = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   dvnd_q, dvnd_d;   // original dividend, returned in hi on divide by zero
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;

  logic               in_ready;
  logic               accept;

  // decode outputs
  logic [WIDTH-1:0]   dec_res;
  logic               dec_ill, dec_wr_hi, dec_wr_lo, dec_mul, dec_div, dec_sgn;
  logic               slt_lt;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // iteration/fix datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem_sh;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign in_ready = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Operation decode from the live request fields; only consumed on accept.
  always_comb begin
    dec_res   = '0;
    dec_ill   = 1'b0;
    dec_wr_hi = 1'b0;
    dec_wr_lo = 1'b0;
    dec_mul   = 1'b0;
    dec_div   = 1'b0;
    dec_sgn   = 1'b0;
    slt_lt    = $signed(bus.a) < $signed(bus.b);
    case (bus.alu_op)
      3'd0: dec_res = bus.a + bus.b;
      3'd1: dec_res = bus.a & bus.b;
      3'd2: begin
        case (bus.funct)
          6'd32: dec_res = bus.a + bus.b;
          6'd34: dec_res = bus.a - bus.b;
          6'd36: dec_res = bus.a & bus.b;
          6'd37: dec_res = bus.a | bus.b;
          6'd42: dec_res = WIDTH'(slt_lt);
          6'd16: dec_res = hi_q;
          6'd18: dec_res = lo_q;
          6'd17: begin dec_res = bus.a; dec_wr_hi = 1'b1; end
          6'd19: begin dec_res = bus.a; dec_wr_lo = 1'b1; end
          6'd24: begin dec_mul = ENABLE_MULDIV; dec_sgn = 1'b1; dec_ill = !ENABLE_MULDIV; end
          6'd25: begin dec_mul = ENABLE_MULDIV; dec_ill = !ENABLE_MULDIV; end
          6'd26: begin dec_div = ENABLE_MULDIV; dec_sgn = 1'b1; dec_ill = !ENABLE_MULDIV; end
          6'd27: begin dec_div = ENABLE_MULDIV; dec_ill = !ENABLE_MULDIV; end
          default: dec_ill = 1'b1;
        endcase
      end
      3'd3: dec_res = bus.a - bus.b;
      3'd4: dec_res = bus.a | bus.b;
      3'd5: dec_res = WIDTH'(slt_lt);
      default: dec_ill = 1'b1;
    endcase
    a_mag = (dec_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag = (dec_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // One shift-add / restoring-subtract step, and sign fix-up of the final values.
  always_comb begin
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial  = div_rem_sh - {1'b0, opnd_q};
    prod_fix   = neg_lo_q ? -acc_q : acc_q;
    if (is_div_q) begin
      if (opnd_q == '0) begin
        fix_lo = '1;
        fix_hi = dvnd_q;
      end else begin
        fix_lo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        fix_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      end
    end else begin
      fix_lo = prod_fix[WIDTH-1:0];
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_d     = state;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    dvnd_d      = dvnd_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (dec_mul) begin
            state_d  = MUL;
            is_div_d = 1'b0;
            acc_d    = {{WIDTH{1'b0}}, b_mag};
            opnd_d   = a_mag;
            neg_lo_d = dec_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_hi_d = 1'b0;
            cnt_d    = '0;
          end else if (dec_div) begin
            state_d  = DIV;
            is_div_d = 1'b1;
            acc_d    = {{WIDTH{1'b0}}, a_mag};
            opnd_d   = b_mag;
            dvnd_d   = bus.a;
            neg_lo_d = dec_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_hi_d = dec_sgn && bus.a[WIDTH-1];
            cnt_d    = '0;
          end else begin
            out_valid_d = 1'b1;
            result_d    = dec_res;
            zero_d      = (dec_res == '0);
            illegal_d   = dec_ill;
            if (dec_wr_hi) hi_d = bus.a;
            if (dec_wr_lo) lo_d = bus.a;
          end
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
      end
      DIV: begin
        if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                   acc_d = {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        illegal_d   = 1'b0;
        hi_d        = fix_hi;
        lo_d        = fix_lo;
        result_d    = fix_lo;
        zero_d      = (fix_lo == '0);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      dvnd_q      <= '0;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
    end else begin
      state       <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      dvnd_q      <= dvnd_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      neg_lo_q    <= neg_lo_d;
      neg_hi_q    <= neg_hi_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a result scoreboard.
`timescale 1ns/1ps
module tb_alu_exec_unit;

  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(WIDTH)) ifc ();
  alu_exec_if #(.WIDTH(WIDTH)) ifc0 ();

  alu_exec_unit #(.WIDTH(WIDTH), .ENABLE_MULDIV(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  alu_exec_unit #(.WIDTH(WIDTH), .ENABLE_MULDIV(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc0)
  );

  typedef struct {
    string       tag;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: expected outputs and architectural HI/LO.
  task automatic model(input string tag, input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, output exp_t e);
    logic [31:0] res;
    logic        ill;
    longint      p;
    logic [63:0] up;
    int          sa_i, sb_i;
    res = '0;
    ill = 1'b0;
    case (op)
      3'd0: res = a + b;
      3'd1: res = a & b;
      3'd3: res = a - b;
      3'd4: res = a | b;
      3'd5: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd2: begin
        case (fn)
          6'd32: res = a + b;
          6'd34: res = a - b;
          6'd36: res = a & b;
          6'd37: res = a | b;
          6'd42: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'd16: res = m_hi;
          6'd18: res = m_lo;
          6'd17: begin m_hi = a; res = a; end
          6'd19: begin m_lo = a; res = a; end
          6'd24: begin
            p = longint'($signed(a)) * longint'($signed(b));
            m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo;
          end
          6'd25: begin
            up = {32'd0, a} * {32'd0, b};
            m_hi = up[63:32]; m_lo = up[31:0]; res = m_lo;
          end
          6'd26: begin
            sa_i = int'(a);
            sb_i = int'(b);
            if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = 32'h8000_0000; m_hi = 32'd0; end
            else begin m_lo = 32'(sa_i / sb_i); m_hi = 32'(sa_i % sb_i); end
            res = m_lo;
          end
          6'd27: begin
            if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
            else begin m_lo = a / b; m_hi = a % b; end
            res = m_lo;
          end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    e.tag     = tag;
    e.result  = res;
    e.zero    = (res == 32'd0);
    e.illegal = ill;
    e.hi      = m_hi;
    e.lo      = m_lo;
  endtask

  // Drive a request, wait for acceptance, and log its expected outcome.
  task automatic issue(input string tag, input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   got;
    got = 1'b0;
    ifc.alu_op   = op;
    ifc.funct    = fn;
    ifc.a        = a;
    ifc.b        = b;
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifc.in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check({tag, ".accept_timeout"}, 32'(ifc.in_ready), 32'd1);
      ifc.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    model(tag, op, fn, a, b, e);
    sb.push_back(e);
  endtask

  // Wait until every issued op has been delivered.
  task automatic drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && ifc.out_valid !== 1'b1) break;
    end
    check({tag, ".drain"}, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: compare each delivered result (valid && ready) against the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(ifc.out_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, ".result"},  ifc.result,        mon_e.result);
        check({mon_e.tag, ".zero"},    32'(ifc.zero),    32'(mon_e.zero));
        check({mon_e.tag, ".illegal"}, 32'(ifc.illegal), 32'(mon_e.illegal));
        check({mon_e.tag, ".hi"},      ifc.hi,            mon_e.hi);
        check({mon_e.tag, ".lo"},      ifc.lo,            mon_e.lo);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    ifc.in_valid = 1'b0; ifc.alu_op = '0; ifc.funct = '0; ifc.a = '0; ifc.b = '0; ifc.out_ready = 1'b1;
    ifc0.in_valid = 1'b0; ifc0.alu_op = '0; ifc0.funct = '0; ifc0.a = '0; ifc0.b = '0; ifc0.out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst.zero",      32'(ifc.zero),      32'd1);
    check("rst.result",    ifc.result,          32'd0);
    check("rst.illegal",   32'(ifc.illegal),   32'd0);
    check("rst.hi",        ifc.hi,              32'd0);
    check("rst.lo",        ifc.lo,              32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst.in_ready",  32'(ifc.in_ready),  32'd1);
    @(posedge clk);
    #1;

    // T2 back-to-back single-cycle ops
    issue("t2.add", 3'd0, 6'd0, 32'd5, 32'd7);
    issue("t2.sub", 3'd3, 6'd0, 32'd3, 32'd3);
    issue("t2.slt", 3'd5, 6'd0, 32'hFFFF_FFFF, 32'd1);
    drain("t2");

    // further single-cycle decode coverage
    issue("r.add_wrap", 3'd2, 6'd32, 32'hFFFF_FFFF, 32'd1);
    issue("r.sub_wrap", 3'd2, 6'd34, 32'd0, 32'd1);
    issue("r.and",      3'd2, 6'd36, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
    issue("r.or",       3'd2, 6'd37, 32'h1200_0000, 32'h0000_0034);
    issue("r.slt_no",   3'd2, 6'd42, 32'd5, 32'hFFFF_FFFD);
    issue("op.and",     3'd1, 6'd0, 32'h0000_FF00, 32'h0000_0FF0);
    issue("op.or",      3'd4, 6'd0, 32'h8000_0000, 32'd1);
    issue("r.mtlo",     3'd2, 6'd19, 32'h0000_1234, 32'd9);
    issue("r.mthi",     3'd2, 6'd17, 32'h0000_ABCD, 32'd9);
    issue("r.mflo",     3'd2, 6'd18, 32'd0, 32'd0);
    issue("r.mfhi",     3'd2, 6'd16, 32'd0, 32'd0);
    drain("single");

    // T3 mult latency and values
    issue("t3.mult", 3'd2, 6'd24, 32'hFFFF_FFFE, 32'd3);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      n++;
      if (ifc.out_valid === 1'b1) break;
      @(posedge clk);
      #1;
    end
    check("t3.mult_latency", 32'(n), 32'(WIDTH + 2));
    drain("t3.mult");
    issue("t3.multu", 3'd2, 6'd25, 32'hFFFF_FFFE, 32'd3);
    drain("t3.multu");
    issue("t3.mfhi", 3'd2, 6'd16, 32'd0, 32'd0);
    issue("mult.big", 3'd2, 6'd24, 32'h8000_0000, 32'h8000_0000);
    issue("multu.zero", 3'd2, 6'd25, 32'h1234_5678, 32'd0);
    drain("mult.more");

    // T4 divides, including divide-by-zero and overflow case
    issue("t4.div",        3'd2, 6'd26, 32'hFFFF_FFF9, 32'd2);
    issue("t4.divu_by0",   3'd2, 6'd27, 32'd7, 32'd0);
    issue("div.by0_neg",   3'd2, 6'd26, 32'hFFFF_FFF9, 32'd0);
    issue("div.min_m1",    3'd2, 6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
    issue("divu.plain",    3'd2, 6'd27, 32'd100, 32'd7);
    issue("div.pos_neg",   3'd2, 6'd26, 32'd100, 32'hFFFF_FFF9);
    issue("divu.big",      3'd2, 6'd27, 32'hFFFF_FFFF, 32'h0000_0010);
    drain("t4");

    // T5 backpressure: result held, no accept while blocked
    ifc.out_ready = 1'b0;
    issue("t5.and", 3'd1, 6'd0, 32'h0000_00F0, 32'h0000_003C);
    ifc.alu_op = 3'd0; ifc.funct = 6'd0; ifc.a = 32'd1; ifc.b = 32'd1; ifc.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5.hold_result",    ifc.result,          32'h0000_0030);
      check("t5.hold_valid",     32'(ifc.out_valid), 32'd1);
      check("t5.hold_in_ready",  32'(ifc.in_ready),  32'd0);
      check("t5.hold_lo",        ifc.lo,              m_lo);
    end
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b1;
    issue("t5.add", 3'd0, 6'd0, 32'd1, 32'd1);
    drain("t5");

    // T6 illegal encodings
    issue("t6.bad_funct", 3'd2, 6'h3F, 32'd11, 32'd22);
    issue("t6.bad_op",    3'd7, 6'd0,  32'd11, 32'd22);
    drain("t6");

    // T6 with mult/div disabled: funct 24 flags illegal, hi/lo untouched
    ifc0.alu_op = 3'd2; ifc0.funct = 6'd17; ifc0.a = 32'h0000_0055; ifc0.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc0.funct = 6'd24; ifc0.a = 32'd6; ifc0.b = 32'd7;
    check("t6n.mthi_hi", ifc0.hi, 32'h0000_0055);
    @(posedge clk);
    #1;
    ifc0.in_valid = 1'b0;
    check("t6n.valid",   32'(ifc0.out_valid), 32'd1);
    check("t6n.illegal", 32'(ifc0.illegal),   32'd1);
    check("t6n.result",  ifc0.result,          32'd0);
    check("t6n.zero",    32'(ifc0.zero),      32'd1);
    check("t6n.hi",      ifc0.hi,              32'h0000_0055);
    check("t6n.lo",      ifc0.lo,              32'd0);
    @(posedge clk);
    #1;
    check("t6n.in_ready", 32'(ifc0.in_ready), 32'd1);

    // T1 reset in the middle of a mult
    issue("t1.mtlo", 3'd2, 6'd19, 32'h0000_0077, 32'd0);
    drain("t1.pre");
    issue("t1.mult", 3'd2, 6'd24, 32'd6, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t1.out_valid", 32'(ifc.out_valid), 32'd0);
    check("t1.hi",        ifc.hi,              32'd0);
    check("t1.lo",        ifc.lo,              32'd0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t1.in_ready", 32'(ifc.in_ready), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    check("t1.no_stale_result", 32'(ifc.out_valid), 32'd0);
    issue("t1.after", 3'd0, 6'd0, 32'd40, 32'd2);
    drain("t1.after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
